// File: rtl/andgate_test_pkg.sv
// andgate_test_pkg -- shared FSM states, default parameters and reference gate function.
// Rev 1.0
`default_nettype none

package andgate_test_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_e;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_BLINK_BIT     = 23;

  function automatic logic expected_y(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// sync2 -- two-flop synchroniser for an asynchronous single-bit input.
// Rev 1.0
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/andgate_checker.sv
// andgate_checker -- checks y == a & b once per stable {a,b}, with counters, coverage and LEDs.
// Rev 1.0
`default_nettype none

module andgate_checker
  import andgate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int BLINK_BIT     = DEF_BLINK_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  input  logic             clr_err,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov,
  output logic             all_seen,
  output logic             led_pass,
  output logic             led_fail
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic a_s;
  logic b_s;
  logic y_s;

  sync2 u_sync_a (.clk(clk), .rst(reset), .d(a), .q(a_s));
  sync2 u_sync_b (.clk(clk), .rst(reset), .d(b), .q(b_s));
  sync2 u_sync_y (.clk(clk), .rst(reset), .d(y), .q(y_s));

  logic [1:0]         ab_s;
  logic [1:0]         ab_prev_q;
  logic               chg;
  logic               mismatch;
  state_e             state_q, state_d;
  logic               first_q, first_d;
  logic [7:0]         settle_q, settle_d;
  logic               do_check;
  logic [CNT_W-1:0]   check_count_q, check_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [3:0]         cov_q, cov_d;
  logic               fault_q, fault_d;
  logic [BLINK_BIT:0] div_q, div_d;

  assign ab_s     = {a_s, b_s};
  assign chg      = (ab_s != ab_prev_q);
  assign mismatch = (y_s != expected_y(a_s, b_s));

  // A change seen in CHECK still lets that compare happen, then restarts settling.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    settle_d = settle_q;
    do_check = 1'b0;
    case (state_q)
      WAIT: begin
        if (first_q || chg) begin
          state_d  = SETTLE;
          settle_d = 8'd0;
          first_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (chg) begin
          settle_d = 8'd0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      CHECK: begin
        do_check = 1'b1;
        if (chg) begin
          state_d  = SETTLE;
          settle_d = 8'd0;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  // Clear beats a coincident compare, so that compare is discarded.
  always_comb begin
    check_count_d = check_count_q;
    err_count_d   = err_count_q;
    cov_d         = cov_q;
    fault_d       = fault_q;
    div_d         = div_q + 1'b1;
    if (clr_err) begin
      check_count_d = '0;
      err_count_d   = '0;
      cov_d         = 4'b0000;
      fault_d       = 1'b0;
    end else if (do_check) begin
      if (check_count_q != CNT_MAX) begin
        check_count_d = check_count_q + 1'b1;
      end
      cov_d[ab_s] = 1'b1;
      if (mismatch) begin
        fault_d = 1'b1;
        if (err_count_q != CNT_MAX) begin
          err_count_d = err_count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_prev_q     <= 2'b00;
      state_q       <= WAIT;
      first_q       <= 1'b1;
      settle_q      <= 8'd0;
      check_count_q <= '0;
      err_count_q   <= '0;
      cov_q         <= 4'b0000;
      fault_q       <= 1'b0;
      div_q         <= '0;
    end else begin
      ab_prev_q     <= ab_s;
      state_q       <= state_d;
      first_q       <= first_d;
      settle_q      <= settle_d;
      check_count_q <= check_count_d;
      err_count_q   <= err_count_d;
      cov_q         <= cov_d;
      fault_q       <= fault_d;
      div_q         <= div_d;
    end
  end

  assign check_count = check_count_q;
  assign err_count   = err_count_q;
  assign cov         = cov_q;
  assign all_seen    = &cov_q;
  assign led_pass    = div_q[BLINK_BIT] & (check_count_q != '0) & ~fault_q;
  assign led_fail    = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_andgate_checker.sv
// tb_andgate_checker -- randomized and directed checks of andgate_checker against an event-level model.
// Rev 1.0
`default_nettype none

module tb_andgate_checker;

  localparam int S  = 4;
  localparam int BB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0, b = 1'b0, y = 1'b0, clr_err = 1'b0;

  logic [15:0] chk_a, err_a;
  logic [2:0]  chk_b, err_b;
  logic [3:0]  cov_a, cov_b;
  logic        all_a, all_b, lp_a, lp_b, lf_a, lf_b;

  andgate_checker #(.SETTLE_CYCLES(S), .CNT_W(16), .BLINK_BIT(BB)) dut_a (
    .clk(clk), .reset(reset), .a(a), .b(b), .y(y), .clr_err(clr_err),
    .check_count(chk_a), .err_count(err_a), .cov(cov_a), .all_seen(all_a),
    .led_pass(lp_a), .led_fail(lf_a)
  );

  andgate_checker #(.SETTLE_CYCLES(S), .CNT_W(3), .BLINK_BIT(BB)) dut_b (
    .clk(clk), .reset(reset), .a(a), .b(b), .y(y), .clr_err(clr_err),
    .check_count(chk_b), .err_count(err_b), .cov(cov_b), .all_seen(all_b),
    .led_pass(lp_b), .led_fail(lf_b)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pins seen by the checker lag the pins by two edges; a check lands
  // S+1 edges after the last change (or the first edge after reset).
  int         k;
  logic [2:0] ph[$];
  int         ev;
  bit         armed;
  int         m_chk, m_err;
  logic [3:0] m_cov;
  bit         m_fault;
  logic [1:0] s_prev;

  function automatic void model_reset();
    k = 0; ph.delete(); ev = 0; armed = 0;
    m_chk = 0; m_err = 0; m_cov = 4'b0; m_fault = 0; s_prev = 2'b00;
  endfunction

  function automatic void model_edge(input logic [2:0] pin, input logic clr);
    logic [2:0] s;
    bit do_chk;
    k++;
    ph.push_back(pin);
    s = (k >= 3) ? ph[k-3] : 3'b000;
    do_chk = armed && (k == ev + S + 1);
    if (do_chk) armed = 0;
    if (clr) begin
      m_chk = 0; m_err = 0; m_cov = 4'b0; m_fault = 0;
    end else if (do_chk) begin
      m_chk++;
      m_cov[s[2:1]] = 1'b1;
      if (s[0] != (s[2] & s[1])) begin
        m_err++;
        m_fault = 1;
      end
    end
    if (k == 1 || s[2:1] != s_prev) begin
      ev = k;
      armed = 1;
    end
    s_prev = s[2:1];
  endfunction

  function automatic logic [15:0] exp_cnt(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? 16'(mx) : 16'(v);
  endfunction

  function automatic logic exp_lp();
    return (((k >> BB) & 1) != 0) && (m_chk != 0) && !m_fault;
  endfunction

  task automatic step(input logic na, input logic nb, input logic ny, input logic nclr);
    a = na; b = nb; y = ny; clr_err = nclr;
    @(posedge clk);
    model_edge({na, nb, ny}, nclr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({chk_a, err_a, cov_a, all_a, lp_a, lf_a} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_a got %h required 0", {chk_a, err_a, cov_a, all_a, lp_a, lf_a});
    end
    n_assert++;
    if ({chk_b, err_b, cov_b, all_b, lp_b, lf_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_b got %h required 0", {chk_b, err_b, cov_b, all_b, lp_b, lf_b});
    end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_walk();
    logic [1:0] c;
    bit seen0, seen1;
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 4; i++) begin
      c = 2'(i);
      for (int j = 0; j < 20; j++) begin
        step(c[1], c[0], c[1] & c[0], 1'b0);
        n_assert++;
        if (lp_a !== exp_lp()) begin
          n_fail++;
          $display("FAIL walk_led_pass edge=%0d got %b required %b", k, lp_a, exp_lp());
        end
        if (lp_a === 1'b1) seen1 = 1;
        if (lp_a === 1'b0 && m_chk != 0) seen0 = 1;
      end
    end
    n_assert++;
    if ({chk_a, err_a} !== {16'd4, 16'd0}) begin
      n_fail++;
      $display("FAIL walk_counts got chk=%0d err=%0d required chk=4 err=0", chk_a, err_a);
    end
    n_assert++;
    if ({cov_a, all_a, lf_a} !== {4'hF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL walk_cov got cov=%b all=%b fail=%b required 1111 1 0", cov_a, all_a, lf_a);
    end
    n_assert++;
    if (!(seen0 && seen1)) begin
      n_fail++;
      $display("FAIL walk_heartbeat got low=%0b high=%0b required both", seen0, seen1);
    end
  endtask

  task automatic test_stuck0();
    int first_i;
    first_i = -1;
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (first_i < 0 && lf_a === 1'b1) first_i = i;
      n_assert++;
      if (lf_a !== m_fault) begin
        n_fail++;
        $display("FAIL stuck_led_fail step=%0d got %b required %b", i, lf_a, m_fault);
      end
    end
    n_assert++;
    if ({chk_a, err_a} !== {16'd6, 16'd1}) begin
      n_fail++;
      $display("FAIL stuck_counts got chk=%0d err=%0d required chk=6 err=1", chk_a, err_a);
    end
    n_assert++;
    if (first_i < 0 || first_i > 7) begin
      n_fail++;
      $display("FAIL stuck_latency got %0d required <=7", first_i);
    end
    n_assert++;
    if ({lp_a, lf_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL stuck_leds got pass=%b fail=%b required 0 1", lp_a, lf_a);
    end
  endtask

  task automatic test_bounce();
    logic av;
    av = 1'b0;
    for (int i = 0; i < 40; i++) begin
      av = ((i / 2) % 2) != 0;
      step(av, 1'b1, av, 1'b0);
      n_assert++;
      if (chk_a !== 16'd6) begin
        n_fail++;
        $display("FAIL bounce_no_check step=%0d got %0d required 6", i, chk_a);
      end
    end
    repeat (20) step(av, 1'b1, av, 1'b0);
    n_assert++;
    if (chk_a !== 16'd7) begin
      n_fail++;
      $display("FAIL bounce_one_check got %0d required 7", chk_a);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] c;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      c = 2'(i % 4);
      repeat (10) step(c[1], c[0], c[1] & c[0], 1'b0);
    end
    n_assert++;
    if ({chk_b, err_b} !== {3'd7, 3'd0}) begin
      n_fail++;
      $display("FAIL sat_narrow got chk=%0d err=%0d required chk=7 err=0", chk_b, err_b);
    end
    n_assert++;
    if ({chk_a, err_a} !== {16'd10, 16'd0}) begin
      n_fail++;
      $display("FAIL sat_wide got chk=%0d err=%0d required chk=10 err=0", chk_a, err_a);
    end
  endtask

  task automatic test_clr_race();
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, i == 7);
    n_assert++;
    if ({chk_a, err_a, cov_a, lf_a} !== 37'd0) begin
      n_fail++;
      $display("FAIL clr_race got chk=%0d err=%0d cov=%b fail=%b required all 0", chk_a, err_a, cov_a, lf_a);
    end
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0);
    n_assert++;
    if ({chk_a, err_a, cov_a} !== {16'd1, 16'd0, 4'b1000}) begin
      n_fail++;
      $display("FAIL clr_after got chk=%0d err=%0d cov=%b required 1 0 1000", chk_a, err_a, cov_a);
    end
  endtask

  task automatic test_reset_mid_settle();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    n_assert++;
    if ({chk_a, err_a, cov_a, all_a, lp_a, lf_a, chk_b, err_b, cov_b, all_b, lp_b, lf_b} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_mid got chk=%0d cov=%b pass=%b fail=%b required 0", chk_a, cov_a, lp_a, lf_a);
    end
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_assert++;
      if (chk_a !== exp_cnt(m_chk, 16)) begin
        n_fail++;
        $display("FAIL reset_recheck_model step=%0d got %0d required %0d", i, chk_a, m_chk);
      end
    end
    n_assert++;
    if ({chk_a, cov_a} !== {16'd1, 4'b0010}) begin
      n_fail++;
      $display("FAIL reset_recheck got chk=%0d cov=%b required 1 0010", chk_a, cov_a);
    end
  endtask

  task automatic test_random();
    logic [1:0]  c;
    int          mode, hold;
    logic        yv;
    logic [15:0] ec, ee;
    logic [38:0] ea;
    logic [12:0] eb;
    for (int n = 0; n < 400; n++) begin
      c    = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 7);
      hold = $urandom_range(1, 10);
      for (int i = 0; i < hold; i++) begin
        yv = c[1] & c[0];
        if (mode == 0 || (mode == 1 && i == 0)) yv = ~yv;
        step(c[1], c[0], yv, $urandom_range(0, 99) == 0);
        ea = {exp_cnt(m_chk, 16), exp_cnt(m_err, 16), m_cov, &m_cov, exp_lp(), m_fault};
        ec = exp_cnt(m_chk, 3);
        ee = exp_cnt(m_err, 3);
        eb = {ec[2:0], ee[2:0], m_cov, &m_cov, exp_lp(), m_fault};
        n_assert++;
        if ({chk_a, err_a, cov_a, all_a, lp_a, lf_a} !== ea) begin
          n_fail++;
          $display("FAIL rand_wide edge=%0d got %h required %h", k, {chk_a, err_a, cov_a, all_a, lp_a, lf_a}, ea);
        end
        n_assert++;
        if ({chk_b, err_b, cov_b, all_b, lp_b, lf_b} !== eb) begin
          n_fail++;
          $display("FAIL rand_narrow edge=%0d got %h required %h", k, {chk_b, err_b, cov_b, all_b, lp_b, lf_b}, eb);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_walk();
    test_stuck0();
    test_bounce();
    test_saturation();
    test_clr_race();
    test_reset_mid_settle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
